// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, 8 data bits LSB first, optional parity, 1 or 2 stop bits
// Ports: clk_i clock; arstn_i async active-low reset; tx_req_i/tx_data_i/tx_rdy_o byte write handshake;
//        tx_o serial line (idles high); busy_o frame on line or FIFO non-empty; fifo_cnt_o FIFO occupancy.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data (PARITY_ODD selects odd).
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 694,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic                          tx_req_i,
  input  logic [7:0]                    tx_data_i,
  output logic                          tx_rdy_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          pend_q, pend_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    head;
  logic          push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  assign head       = mem_q[rd_ptr_q];
  assign tx_rdy_o   = cnt_q != CW'(FIFO_DEPTH);
  assign push       = tx_req_i && tx_rdy_o;
  assign bit_end    = baud_q == 16'(BAUD_DIV - 1);
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) || (cnt_q != '0);
  assign fifo_cnt_o = cnt_q;
  // pend_q delays the IDLE start decision by one clock so a byte written into
  // an empty FIFO at edge E starts its frame at edge E+2
  assign pend_d = cnt_q != '0;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      if (pend_q) begin
        pop     = 1'b1;
        tx_d    = 1'b0;
        state_d = START;
      end
    end else if (bit_end) begin
      if (state_q == START) begin
        tx_d    = shreg_q[0];
        bit_d   = '0;
        state_d = DATA;
      end else if (state_q == DATA) begin
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          tx_d    = 1'b1;
          state_d = STOP;
`endif
        end else begin
          tx_d = shreg_q[1];
        end
`ifdef UART_TX_PARITY_EN
      end else if (state_q == PARITY) begin
        tx_d    = 1'b1;
        bit_d   = '0;
        state_d = STOP;
`endif
      end else begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(STOP_BITS - 1)) begin
          bit_d   = '0;
          pop     = cnt_q != '0;
          tx_d    = !pop;
          state_d = pop ? START : IDLE;
        end
      end
    end
    if (pop) shreg_d = head;
  end
`ifdef UART_TX_PARITY_EN
  assign par_d = pop ? ((PARITY_ODD != 0) ? ~^head : ^head) : par_q;
`endif
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = tx_data_i;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      pend_q   <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      pend_q   <= pend_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter. It sits at the host/test-fixture end of the SoC serial link and drives the line the SoC's `rx_i` samples.
- Also reusable inside the SoC as a console/debug transmitter.
- Accepts bytes over a req/rdy handshake into a small FIFO and serialises them as 8-bit, LSB-first frames.
- Frame: start bit, optional parity bit, 1 or 2 stop bits, at a fixed clock-derived baud rate.

Parameters:
- BAUD_DIV, 694, clocks per bit (80 MHz / 115200, rounded down); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- clk_i  input  1  system clock.
- arstn_i  input  1  reset; asynchronous assert, active-low.
- tx_req_i  input  1  write request.
- tx_data_i  input  8  byte to send; sampled when tx_req_i && tx_rdy_o.
- tx_rdy_o  output  1  FIFO not full; combinational from the FIFO count.
- tx_o  output  1  serial line; idles high; registered.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low (arstn_i).
- Reset values:
  - tx_o = 1, tx_rdy_o = 1, busy_o = 0, fifo_cnt_o = 0.
  - FSM = IDLE; bit counter and baud counter = 0.
  - FIFO pointers = 0.
- Accept rule: a write is taken at a rising edge when tx_req_i && tx_rdy_o. The data is written at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
- Full boundary: when fifo_cnt_o == FIFO_DEPTH, tx_rdy_o = 0. A write in the same cycle as a pop while full is not accepted; no overflow can occur.
- Requests while tx_rdy_o = 0 are ignored with no side effects; the requester holds tx_req_i.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the shift register, tx_o <= 0, go to START, clear the baud counter.
  - Latency: a byte accepted into an empty FIFO at edge E appears as a start-bit low on tx_o from edge E+2.
- Bit timing: each state holds its tx_o value for exactly BAUD_DIV clocks. The baud counter counts 0..BAUD_DIV-1; the bit ends at BAUD_DIV-1.
- START -> DATA: tx_o <= shreg[0].
- DATA:
  - 8 bits, LSB first; the register shifts right at each bit end.
  - After bit 7 the FSM goes to PARITY if parity is compiled in, otherwise to STOP with tx_o <= 1.
- PARITY -> STOP: tx_o <= 1.
- STOP:
  - Lasts STOP_BITS x BAUD_DIV clocks with tx_o = 1.
  - At the end, if the FIFO is non-empty: pop and go directly to START, with no idle clock between frames.
  - Otherwise go to IDLE.
- Pop and write in the same cycle with the FIFO non-full: both happen and fifo_cnt_o is unchanged.
- busy_o = (state != IDLE) || (fifo_cnt_o != 0), registered-equivalent timing.
- Mid-operation reset: tx_o goes high immediately (asynchronously). FIFO contents are discarded and the partial frame is abandoned.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - Parity bit = ^data for even parity (PARITY_ODD = 0) or ~^data for odd parity (PARITY_ODD = 1).
  - Frame = 11 bits with STOP_BITS = 1.
- Undefined:
  - No PARITY state and no parity logic; PARITY_ODD is ignored.
  - Frame = 10 bits with STOP_BITS = 1.

Test Plan (all with BAUD_DIV = 4):
- Reset: arstn_i = 0 for any cycles -> tx_o = 1, tx_rdy_o = 1, busy_o = 0, fifo_cnt_o = 0. Also assert reset between clock edges -> outputs change without waiting for an edge.
- Single byte, no parity, STOP_BITS = 1: write 0x55 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each level 4 clocks, 40 clocks total; start low from edge E+2; busy_o low after the stop bit.
- Burst: hold tx_req_i with 0x01..0x05, FIFO_DEPTH = 4 -> tx_rdy_o drops after 4 are buffered and re-rises after the first pop; all 5 frames are contiguous with no idle clock; bytes are received in order.
- Parity, UART_TX_PARITY_EN defined, byte 0x07:
  - PARITY_ODD = 0 -> parity bit 1.
  - PARITY_ODD = 1 -> parity bit 0.
  - Frame = 44 clocks.
- STOP_BITS = 2, bytes 0xA5 then 0x3C -> 8 clocks high between frames, then the start of the next frame immediately.
- Reset during data bit 3 of 0xF0 with 2 bytes queued -> tx_o = 1 asynchronously and fifo_cnt_o = 0. After release, writing 0x81 produces one clean 40-clock frame and no stale bytes.
